// File: rtl/soc_boot_defs.sv
// soc_boot_defs: shared loader state encodings and frame-format constants
package soc_boot_defs;
  typedef enum logic [2:0] {RUN, WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM, ERR} state_t;
  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam int LEN_BYTES = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer: packs a byte stream little-endian into words with a one-cycle word_valid
module imem_byte_packer
  import soc_boot_defs::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_in,
  output logic                  last_byte,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_valid
);
  logic [1:0] cnt;
  assign last_byte = cnt == 2'(BYTES_PER_WORD - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      word <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && last_byte && !clr;
      cnt <= clr ? 2'd0 : byte_valid ? cnt + 2'd1 : cnt;
      if (byte_valid) word <= {byte_in, word[DATA_WIDTH-1:8]};
    end
  end
endmodule

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: loads a framed UART program image into instruction memory while holding the CPU
module imem_boot_loader
  import soc_boot_defs::*;
#(
  parameter int         DATA_WIDTH    = 32,
  parameter int         ADDR_WIDTH    = 13,
  parameter int         WORD_NUM      = (2**ADDR_WIDTH)/4,
  parameter logic [7:0] SYNC_BYTE     = DEF_SYNC_BYTE,
  parameter int         TIMEOUT_CYC   = 1000000,
  parameter bit         BOOT_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  boot_req,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-2:0] words_loaded
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  state_t state, nxt;
  logic [7:0] len_lo, csum;
  logic [15:0] total, len;
  logic [TW-1:0] tcnt;
  logic last_byte, sync_hit, timeout;
  assign len = {rx_data, len_lo};
  assign busy = state inside {LEN_LO, LEN_HI, DATA, CSUM};
  assign sync_hit = (state == WAIT_SYNC || state == ERR) && rx_valid && rx_data == SYNC_BYTE;
  assign timeout = busy && !rx_valid && tcnt == TW'(TIMEOUT_CYC - 1);
  assign mem_addr = state == RUN ? cpu_addr : {words_loaded[ADDR_WIDTH-3:0], 2'b00};
  imem_byte_packer #(.DATA_WIDTH(DATA_WIDTH)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (sync_hit),
    .byte_valid (state == DATA && rx_valid),
    .byte_in    (rx_data),
    .last_byte  (last_byte),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );
  always_comb begin
    nxt = state;
    case (state)
      RUN:            nxt = boot_req ? WAIT_SYNC : RUN;
      WAIT_SYNC, ERR: nxt = sync_hit ? LEN_LO : state;
      LEN_LO:         nxt = rx_valid ? LEN_HI : LEN_LO;
      LEN_HI:         nxt = !rx_valid ? LEN_HI : len > 16'(WORD_NUM) ? ERR : len == 16'd0 ? CSUM : DATA;
      DATA:           nxt = rx_valid && last_byte && 16'(words_loaded + 1'b1) == total ? CSUM : DATA;
      CSUM:           nxt = !rx_valid ? CSUM : rx_data == csum ? RUN : ERR;
      default:        nxt = ERR;
    endcase
    if (timeout) nxt = ERR;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= BOOT_ON_RESET ? WAIT_SYNC : RUN;
      cpu_hold <= BOOT_ON_RESET;
      done <= 1'b0;
      err <= 1'b0;
      words_loaded <= '0;
      len_lo <= '0;
      total <= '0;
      csum <= '0;
      tcnt <= '0;
    end else begin
      state <= nxt;
      cpu_hold <= nxt != RUN;
      tcnt <= busy && !rx_valid ? tcnt + 1'b1 : '0;
      done <= !sync_hit && (done || (state == CSUM && nxt == RUN));
      err <= !sync_hit && (err || nxt == ERR);
      if (state == LEN_LO && rx_valid) len_lo <= rx_data;
      if (state == LEN_HI && rx_valid) total <= len;
      if (sync_hit) csum <= '0;
      else if (state == DATA && rx_valid) csum <= csum ^ rx_data;
      if (sync_hit) words_loaded <= '0;
      else if (mem_we) words_loaded <= words_loaded + 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic boot_req = 1'b0;
  logic rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic [12:0] cpu_addr = '0;
  logic [12:0] mem_addr;
  logic mem_we;
  logic [31:0] mem_wdata;
  logic cpu_hold, busy, done, err;
  logic [11:0] words_loaded;
  int nvec = 0;
  int nerr = 0;
  logic [12:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [7:0] fr[$];
  always #5 clk = ~clk;
  imem_boot_loader #(.TIMEOUT_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .boot_req     (boot_req),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .cpu_addr     (cpu_addr),
    .mem_addr     (mem_addr),
    .mem_we       (mem_we),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    step();
    rx_valid = 1'b0;
  endtask
  task automatic send_all(input logic [7:0] q[$]);
    foreach (q[i]) send(q[i]);
  endtask
  task automatic boot();
    boot_req = 1'b1;
    step();
    boot_req = 1'b0;
  endtask
  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL reset_cpu_hold got %b want 1", cpu_hold); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL reset_err got %b want 0", err); end
    nvec++; if (mem_we !== 1'b0) begin nerr++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
    nvec++; if (words_loaded !== 12'd0) begin nerr++; $display("FAIL reset_words got %0d want 0", words_loaded); end
    nvec++; if (mem_addr !== 13'h000) begin nerr++; $display("FAIL reset_mem_addr got %h want 000", mem_addr); end
  endtask
  task automatic test_good_frame();
    clear_log();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00};
    send_all(fr);
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL good_busy got %b want 1", busy); end
    nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL good_hold_pre got %b want 1", cpu_hold); end
    send(8'h91);
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL good_done got %b want 1", done); end
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL good_err got %b want 0", err); end
    nvec++; if (cpu_hold !== 1'b0) begin nerr++; $display("FAIL good_hold_post got %b want 0", cpu_hold); end
    nvec++; if (words_loaded !== 12'd2) begin nerr++; $display("FAIL good_words got %0d want 2", words_loaded); end
    nvec++; if (wr_addr.size() !== 2) begin nerr++; $display("FAIL good_nwrites got %0d want 2", wr_addr.size()); end
    else begin
      nvec++; if (wr_addr[0] !== 13'h000 || wr_data[0] !== 32'h00000093) begin nerr++; $display("FAIL good_w0 got %h:%h want 000:00000093", wr_addr[0], wr_data[0]); end
      nvec++; if (wr_addr[1] !== 13'h004 || wr_data[1] !== 32'h00100113) begin nerr++; $display("FAIL good_w1 got %h:%h want 004:00100113", wr_addr[1], wr_data[1]); end
    end
  endtask
  task automatic test_passthrough();
    clear_log();
    cpu_addr = 13'h1F4;
    #1;
    nvec++; if (mem_addr !== 13'h1F4) begin nerr++; $display("FAIL pass_addr got %h want 1f4", mem_addr); end
    boot_req = 1'b1;
    rx_valid = 1'b1;
    rx_data = 8'hA5;
    step();
    boot_req = 1'b0;
    rx_valid = 1'b0;
    nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL pass_hold got %b want 1", cpu_hold); end
    send(8'h00);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL pass_drop_byte busy got %b want 0", busy); end
    fr = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_all(fr);
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL empty_done got %b want 1", done); end
    nvec++; if (words_loaded !== 12'd0) begin nerr++; $display("FAIL empty_words got %0d want 0", words_loaded); end
    nvec++; if (cpu_hold !== 1'b0) begin nerr++; $display("FAIL empty_hold got %b want 0", cpu_hold); end
    nvec++; if (wr_addr.size() !== 0) begin nerr++; $display("FAIL empty_writes got %0d want 0", wr_addr.size()); end
  endtask
  task automatic test_bad_csum();
    boot();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13, 8'h01, 8'h10, 8'h00, 8'h90};
    send_all(fr);
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL bad_err got %b want 1", err); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL bad_done got %b want 0", done); end
    nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL bad_hold got %b want 1", cpu_hold); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL bad_busy got %b want 0", busy); end
    fr[11] = 8'h91;
    send_all(fr);
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL recover_err got %b want 0", err); end
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL recover_done got %b want 1", done); end
    nvec++; if (cpu_hold !== 1'b0) begin nerr++; $display("FAIL recover_hold got %b want 0", cpu_hold); end
  endtask
  task automatic test_len_overflow();
    boot();
    clear_log();
    fr = '{8'hA5, 8'h01, 8'h08};
    send_all(fr);
    nvec++; if (err !== 1'b1) begin nerr++; $display("FAIL ovf_err got %b want 1", err); end
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL ovf_busy got %b want 0", busy); end
    fr = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_all(fr);
    step();
    nvec++; if (wr_addr.size() !== 0) begin nerr++; $display("FAIL ovf_writes got %0d want 0", wr_addr.size()); end
    nvec++; if (cpu_hold !== 1'b1) begin nerr++; $display("FAIL ovf_hold got %b want 1", cpu_hold); end
  endtask
  task automatic test_timeout();
    fr = '{8'hA5, 8'h01};
    send_all(fr);
    nvec++; if (err !== 1'b0) begin nerr++; $display("FAIL to_err_cleared got %b want 0", err); end
    repeat (15) step();
    nvec++; if (err !== 1'b0 || busy !== 1'b1) begin nerr++; $display("FAIL to_early got err=%b busy=%b want err=0 busy=1", err, busy); end
    step();
    nvec++; if (err !== 1'b1 || busy !== 1'b0) begin nerr++; $display("FAIL to_fire got err=%b busy=%b want err=1 busy=0", err, busy); end
  endtask
  task automatic test_midframe_reset();
    clear_log();
    fr = '{8'hA5, 8'h02, 8'h00, 8'h93, 8'h00, 8'h00, 8'h00, 8'h13};
    send_all(fr);
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    nvec++; if (cpu_hold !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || mem_we !== 1'b0) begin nerr++; $display("FAIL mr_outputs got hold=%b busy=%b done=%b err=%b we=%b want 1 0 0 0 0", cpu_hold, busy, done, err, mem_we); end
    nvec++; if (words_loaded !== 12'd0) begin nerr++; $display("FAIL mr_words got %0d want 0", words_loaded); end
    repeat (4) step();
    nvec++; if (wr_addr.size() !== 1) begin nerr++; $display("FAIL mr_nwrites got %0d want 1", wr_addr.size()); end
    else begin
      nvec++; if (wr_addr[0] !== 13'h000 || wr_data[0] !== 32'h00000093) begin nerr++; $display("FAIL mr_w0 got %h:%h want 000:00000093", wr_addr[0], wr_data[0]); end
    end
  endtask
  initial begin
    step();
    test_reset();
    test_good_frame();
    test_passthrough();
    test_bad_csum();
    test_len_overflow();
    test_timeout();
    test_midframe_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Controls the instruction ROM's contents at run time. Receives a framed program image as a byte stream from the UART receiver, packs bytes into 32-bit words and writes them into instruction memory.
- Holds the CPU in reset while loading, then releases it.
- Owns the instruction-memory address port: it drives the port during a load and passes the CPU fetch address through otherwise.

Parameters:
- DATA_WIDTH, 32, instruction word width (fixed 4 bytes).
- ADDR_WIDTH, 13, byte-address width of instruction memory.
- WORD_NUM, (2**ADDR_WIDTH)/4, capacity in words.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYC, 1000000, maximum idle cycles between bytes inside a frame.
- BOOT_ON_RESET, 1, 1 means enter WAIT_SYNC after reset; 0 means enter RUN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- boot_req  in  1  single-cycle request to enter load mode
- rx_valid  in  1  byte strobe from UART RX, at most one per cycle
- rx_data  in  8  received byte
- cpu_addr  in  ADDR_WIDTH  CPU fetch byte address
- mem_addr  out  ADDR_WIDTH  address to instruction memory
- mem_we  out  1  word write strobe
- mem_wdata  out  DATA_WIDTH  word to write
- cpu_hold  out  1  high holds CPU in reset
- busy  out  1  frame in progress
- done  out  1  sticky: last frame loaded with good checksum
- err  out  1  sticky: last frame failed
- words_loaded  out  ADDR_WIDTH-1  number of words written in the current or last frame

Behaviour:
- Reset (rst_n low at posedge clk):
  - State = WAIT_SYNC if BOOT_ON_RESET, else RUN.
  - cpu_hold = BOOT_ON_RESET.
  - mem_we = 0; busy, done, err = 0; words_loaded = 0.
  - Internal byte and word counters, checksum and timeout counter = 0.
- Reset mid-frame aborts the frame. Words already written are not rolled back.
- mem_addr:
  - In RUN: equals cpu_addr, combinational.
  - In all other states: equals the write address word_idx*4.
- States and transitions:
  - RUN: boot_req -> WAIT_SYNC. cpu_hold rises on the next cycle.
  - WAIT_SYNC: rx_data == SYNC_BYTE -> LEN_LO, clearing done, err, checksum and words_loaded. Any other byte is discarded. There is no timeout in this state.
  - LEN_LO: the byte is the low byte of the word count -> LEN_HI.
  - LEN_HI: the byte is the high byte (count is little-endian 16-bit).
    - Count > WORD_NUM -> ERR.
    - Count == 0 -> CSUM.
    - Otherwise -> DATA.
  - DATA: bytes are packed little-endian (first byte goes to [7:0]). Each data byte is XORed into the checksum.
    - When the 4th byte of a word is accepted in cycle N, mem_we = 1 for exactly cycle N+1, with mem_wdata = the packed word and address = word_idx*4.
    - word_idx and words_loaded increment in cycle N+1.
    - After the last word -> CSUM.
  - CSUM:
    - Byte == checksum -> RUN with done = 1; cpu_hold falls on the next cycle.
    - Byte != checksum -> ERR.
  - ERR: err = 1, cpu_hold stays 1. A SYNC_BYTE restarts the frame (as in WAIT_SYNC). Any other byte is ignored.
- busy = 1 in LEN_LO, LEN_HI, DATA and CSUM.
- Timeout: in LEN_LO, LEN_HI, DATA or CSUM, TIMEOUT_CYC consecutive cycles without rx_valid -> ERR. The counter clears on every accepted byte.
- boot_req outside RUN is ignored.
- boot_req and rx_valid in the same cycle while in RUN: state becomes WAIT_SYNC and the byte is dropped.
- cpu_hold is registered and glitch-free.

Decomposition:
- Shared header soc_boot_defs:
  - state encodings (RUN, WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM, ERR)
  - default SYNC_BYTE
  - frame-format constants
- One sub-module, imem_byte_packer. It takes a byte strobe and produces a word plus a one-cycle word_valid, and holds the 2-bit byte counter, the shift register and the clear input.

Test Plan:
- Reset with BOOT_ON_RESET=1, then stream A5 02 00 93 00 00 00 13 01 10 00 91 -> mem_we pulses with (0x000, 0x00000093) and (0x004, 0x00100113), words_loaded=2, done=1, cpu_hold falls one cycle after the checksum byte.
- Same frame with checksum byte 0x90 -> err=1, done=0, cpu_hold stays 1. A correct frame sent afterwards clears err and sets done.
- Length bytes 01 08 (0x0801 > 2048) -> ERR immediately after LEN_HI, with no mem_we.
- In RUN, drive cpu_addr=0x1F4 -> mem_addr=0x1F4. Then boot_req -> cpu_hold=1 on the next cycle, and A5 00 00 00 -> done=1 with no writes.
- Send the sync byte and one length byte, then go idle for TIMEOUT_CYC cycles (TIMEOUT_CYC overridden to 16) -> err=1 on cycle 16, busy=0.
- Assert rst_n low after 5 data bytes -> all outputs return to reset values. The word at 0x000 remains written and no partial write of word 1 occurs.
